// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding and bus levels.
package mem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic RST_ACTIVE    = 1'b0;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant between the fetch and data masters.
// The priority bit remembers who finished last; after reset data wins.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_inst,
  input  logic i_req_data,
  input  logic i_done,
  input  logic i_done_inst,
  output logic o_gnt_inst,
  output logic o_gnt_data
);

  logic r_prio_inst;

  // Hand priority to the master that did not complete the last transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      r_prio_inst <= 1'b0;
    end else if (i_done) begin
      r_prio_inst <= ~i_done_inst;
    end
  end

  assign o_gnt_inst = i_req_inst & (~i_req_data | r_prio_inst);
  assign o_gnt_data = i_req_data & (~i_req_inst | ~r_prio_inst);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between an instruction-fetch master and a data
// master, one transaction at a time, with an ack timeout that reports
// bus_err_o and returns zero read data.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_ce_i,
  input  logic [ADDR_W-1:0]   inst_addr_i,
  output logic [DATA_W-1:0]   inst_data_o,
  output logic                inst_ready_o,
  input  logic                data_ce_i,
  input  logic                data_we_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  input  logic [DATA_W/8-1:0] data_sel_i,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                data_ready_o,
  output logic                mem_ce_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_sel_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_ack_i,
  output logic                bus_err_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              r_state;
  logic                r_gnt_inst;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_mem_ce;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [SEL_W-1:0]    r_mem_sel;
  logic [DATA_W-1:0]   r_inst_data;
  logic [DATA_W-1:0]   r_data_rdata;
  logic                r_inst_ready;
  logic                r_data_ready;
  logic                r_bus_err;

  logic                w_gnt_inst;
  logic                w_gnt_data;
  logic                w_done;

  // An acked transaction is the only event that advances round-robin.
  assign w_done = (r_state == ST_BUSY) && mem_ack_i;

  rr_arbiter2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .i_req_inst  (inst_ce_i),
    .i_req_data  (data_ce_i),
    .i_done      (w_done),
    .i_done_inst (r_gnt_inst),
    .o_gnt_inst  (w_gnt_inst),
    .o_gnt_data  (w_gnt_data)
  );

  // Transaction FSM: grant in IDLE, hold the bus in BUSY until ack or timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      r_state      <= ST_IDLE;
      r_gnt_inst   <= 1'b0;
      r_cnt        <= '0;
      r_mem_ce     <= CHIP_DISABLE;
      r_mem_we     <= WRITE_DISABLE;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_sel    <= '0;
      r_inst_data  <= '0;
      r_data_rdata <= '0;
      r_inst_ready <= 1'b0;
      r_data_ready <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_inst_ready <= 1'b0;
      r_data_ready <= 1'b0;
      r_bus_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_inst || w_gnt_data) begin
            r_state    <= ST_BUSY;
            r_gnt_inst <= w_gnt_inst;
            r_cnt      <= '0;
            r_mem_ce   <= CHIP_ENABLE;
            if (w_gnt_inst) begin
              r_mem_we    <= WRITE_DISABLE;
              r_mem_addr  <= inst_addr_i;
              r_mem_wdata <= '0;
              r_mem_sel   <= '1;
            end else begin
              r_mem_we    <= data_we_i ? WRITE_ENABLE : WRITE_DISABLE;
              r_mem_addr  <= data_addr_i;
              r_mem_wdata <= data_wdata_i;
              r_mem_sel   <= data_sel_i;
            end
          end
        end
        ST_BUSY: begin
          if (mem_ack_i || (r_cnt == CNT_LAST)) begin
            // Ack beats a simultaneous timeout; timeout reads return zero.
            r_state   <= ST_IDLE;
            r_mem_ce  <= CHIP_DISABLE;
            r_bus_err <= ~mem_ack_i;
            if (r_gnt_inst) begin
              r_inst_data  <= mem_ack_i ? mem_rdata_i : '0;
              r_inst_ready <= 1'b1;
            end else begin
              if (r_mem_we == WRITE_DISABLE) begin
                r_data_rdata <= mem_ack_i ? mem_rdata_i : '0;
              end
              r_data_ready <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_ce_o     = r_mem_ce;
  assign mem_we_o     = r_mem_we;
  assign mem_addr_o   = r_mem_addr;
  assign mem_wdata_o  = r_mem_wdata;
  assign mem_sel_o    = r_mem_sel;
  assign inst_data_o  = r_inst_data;
  assign inst_ready_o = r_inst_ready;
  assign data_rdata_o = r_data_rdata;
  assign data_ready_o = r_data_ready;
  assign bus_err_o    = r_bus_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          inst_ce_i = 1'b0;
  logic [AW-1:0] inst_addr_i = '0;
  logic [DW-1:0] inst_data_o;
  logic          inst_ready_o;
  logic          data_ce_i = 1'b0;
  logic          data_we_i = 1'b0;
  logic [AW-1:0] data_addr_i = '0;
  logic [DW-1:0] data_wdata_i = '0;
  logic [SW-1:0] data_sel_i = '0;
  logic [DW-1:0] data_rdata_o;
  logic          data_ready_o;
  logic          mem_ce_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [SW-1:0] mem_sel_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          mem_ack_i = 1'b0;
  logic          bus_err_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // Memory responder controls
  int            ack_delay = -1;
  bit            rand_resp = 1'b0;
  logic [DW-1:0] rd_val = '0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_ce_i    (inst_ce_i),
    .inst_addr_i  (inst_addr_i),
    .inst_data_o  (inst_data_o),
    .inst_ready_o (inst_ready_o),
    .data_ce_i    (data_ce_i),
    .data_we_i    (data_we_i),
    .data_addr_i  (data_addr_i),
    .data_wdata_i (data_wdata_i),
    .data_sel_i   (data_sel_i),
    .data_rdata_o (data_rdata_o),
    .data_ready_o (data_ready_o),
    .mem_ce_o     (mem_ce_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_sel_o    (mem_sel_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i),
    .bus_err_o    (bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_ctrl"}, {mem_ce_o, mem_we_o, mem_sel_o, inst_ready_o, data_ready_o, bus_err_o}, 64'd0);
    chk({pfx, "_addr"}, mem_addr_o, 64'd0);
    chk({pfx, "_wdata"}, mem_wdata_o, 64'd0);
    chk({pfx, "_idata"}, inst_data_o, 64'd0);
    chk({pfx, "_drdata"}, data_rdata_o, 64'd0);
  endtask

  // Run one transaction of one master to its ready pulse; snapshot the bus
  // on the first mem_ce_o cycle and count how long mem_ce_o stayed high.
  task automatic run_txn(input bit inst, input string nm, output int ce_cyc,
                         output logic [AW-1:0] s_addr, output logic [DW-1:0] s_wdata,
                         output logic [SW-1:0] s_sel, output logic s_we);
    bit done;
    done = 1'b0;
    ce_cyc = 0;
    s_addr = '0; s_wdata = '0; s_sel = '0; s_we = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (mem_ce_o) begin
        if (ce_cyc == 0) begin
          s_addr = mem_addr_o; s_wdata = mem_wdata_o; s_sel = mem_sel_o; s_we = mem_we_o;
        end
        ce_cyc++;
      end
      if (inst ? inst_ready_o : data_ready_o) begin
        done = 1'b1;
        break;
      end
    end
    if (inst) inst_ce_i = 1'b0;
    else data_ce_i = 1'b0;
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: no ready pulse, got none within 100 cycles, expected one", nm);
    end
  endtask

  // Memory side: ack a fixed or random number of cycles into each access.
  initial begin : responder
    int ce_age;
    int dly;
    ce_age = 0;
    dly = -1;
    forever begin
      @(posedge clk);
      #1;
      if (rst && mem_ce_o) begin
        ce_age++;
        if (ce_age == 1) dly = rand_resp ? int'($urandom_range(0, 20)) : ack_delay;
        mem_ack_i   = (ce_age == dly + 1);
        mem_rdata_i = rand_resp ? DW'($urandom) : rd_val;
      end else begin
        ce_age = 0;
        mem_ack_i   = rand_resp ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata_i = rand_resp ? DW'($urandom) : rd_val;
      end
    end
  end

  // Reference model: whole transactions, counting how long the bus has been held.
  bit            m_busy, m_own_inst, m_pref_inst, m_irdy, m_drdy, m_err;
  int            m_age;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_idata, m_drdata;
  logic [SW-1:0] m_sel;

  initial begin : model
    logic [DW-1:0] v;
    bit            timed_out;
    m_busy = 0; m_own_inst = 0; m_pref_inst = 0; m_irdy = 0; m_drdy = 0; m_err = 0;
    m_age = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_idata = '0; m_drdata = '0; m_sel = '0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_busy = 0; m_own_inst = 0; m_pref_inst = 0; m_irdy = 0; m_drdy = 0; m_err = 0;
        m_age = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_idata = '0; m_drdata = '0; m_sel = '0;
      end else begin
        m_irdy = 0; m_drdy = 0; m_err = 0;
        if (!m_busy) begin
          if (inst_ce_i || data_ce_i) begin
            m_own_inst = inst_ce_i && (!data_ce_i || m_pref_inst);
            m_busy = 1;
            m_age = 1;
            if (m_own_inst) begin
              m_we = 1'b0; m_addr = inst_addr_i; m_wdata = '0; m_sel = '1;
            end else begin
              m_we = data_we_i; m_addr = data_addr_i; m_wdata = data_wdata_i; m_sel = data_sel_i;
            end
          end
        end else if (mem_ack_i || m_age == TO) begin
          timed_out = !mem_ack_i;
          v = timed_out ? '0 : mem_rdata_i;
          if (m_own_inst) begin
            m_idata = v; m_irdy = 1;
          end else begin
            if (!m_we) m_drdata = v;
            m_drdy = 1;
          end
          m_err = timed_out;
          if (!timed_out) m_pref_inst = !m_own_inst;
          m_busy = 0;
        end else begin
          m_age++;
        end
      end
    end
  end

  // Every cycle out of reset, all outputs must match the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("mem_ce", mem_ce_o, m_busy);
        chk("mem_we", mem_we_o, m_we);
        chk("mem_addr", mem_addr_o, m_addr);
        chk("mem_wdata", mem_wdata_o, m_wdata);
        chk("mem_sel", mem_sel_o, m_sel);
        chk("inst_data", inst_data_o, m_idata);
        chk("inst_ready", inst_ready_o, m_irdy);
        chk("data_rdata", data_rdata_o, m_drdata);
        chk("data_ready", data_ready_o, m_drdy);
        chk("bus_err", bus_err_o, m_err);
        chk("ready_excl", inst_ready_o & data_ready_o, 1'b0);
      end
    end
  end

  initial begin : main
    int            cyc;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_sel;
    logic          s_we;
    int            nr, ng;
    bit            prev, seen;
    logic [AW-1:0] order [4];
    logic [AW-1:0] exp_order [4];

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    step();

    // Single fetch, ack three cycles into the access
    ack_delay = 2; rd_val = 32'h0050_0093;
    inst_addr_i = 32'h4; inst_ce_i = 1'b1;
    run_txn(1'b1, "fetch", cyc, s_addr, s_wdata, s_sel, s_we);
    chk("fetch_addr", s_addr, 32'h4);
    chk("fetch_sel", s_sel, 4'hF);
    chk("fetch_we_wdata", {s_we, s_wdata}, 33'd0);
    chk("fetch_ce_cycles", cyc, 3);
    chk("fetch_data", inst_data_o, 32'h0050_0093);
    step();
    chk("fetch_single_pulse", inst_ready_o, 1'b0);

    // Both masters held for four transactions
    ack_delay = 1; rd_val = 32'hA5A5_0001;
    inst_addr_i = 32'h1000; data_addr_i = 32'h2000; data_we_i = 1'b0;
    data_sel_i = 4'hF; data_wdata_i = '0;
    inst_ce_i = 1'b1; data_ce_i = 1'b1;
    nr = 0; ng = 0; prev = 1'b0;
    exp_order[0] = 32'h2000; exp_order[1] = 32'h1000;
    exp_order[2] = 32'h2000; exp_order[3] = 32'h1000;
    for (int k = 0; k < 4; k++) order[k] = '0;
    for (int i = 0; i < 100 && nr < 4; i++) begin
      step();
      if (mem_ce_o && !prev && ng < 4) begin
        order[ng] = mem_addr_o;
        ng++;
      end
      prev = mem_ce_o;
      if (inst_ready_o || data_ready_o) nr++;
    end
    inst_ce_i = 1'b0; data_ce_i = 1'b0;
    chk("cont_done", nr, 4);
    for (int k = 0; k < 4; k++) chk("cont_order", order[k], exp_order[k]);
    chk("cont_idata", inst_data_o, 32'hA5A5_0001);
    chk("cont_drdata", data_rdata_o, 32'hA5A5_0001);
    step();

    // Byte write leaves the read data untouched
    ack_delay = 0; rd_val = 32'h1234_5678;
    data_we_i = 1'b1; data_addr_i = 32'h100; data_wdata_i = 32'hDEAD_BEEF; data_sel_i = 4'b0010;
    data_ce_i = 1'b1;
    run_txn(1'b0, "write", cyc, s_addr, s_wdata, s_sel, s_we);
    data_we_i = 1'b0;
    chk("wr_we", s_we, 1'b1);
    chk("wr_sel", s_sel, 4'b0010);
    chk("wr_wdata", s_wdata, 32'hDEAD_BEEF);
    chk("wr_addr", s_addr, 32'h100);
    chk("wr_rdata_kept", data_rdata_o, 32'hA5A5_0001);
    chk("wr_no_err", bus_err_o, 1'b0);
    step();

    // Timeout on a data read that is never acked
    ack_delay = -1; rd_val = 32'h7777_7777;
    data_addr_i = 32'h300; data_sel_i = 4'hF; data_ce_i = 1'b1;
    run_txn(1'b0, "timeout", cyc, s_addr, s_wdata, s_sel, s_we);
    chk("to_ce_cycles", cyc, TO);
    chk("to_err", bus_err_o, 1'b1);
    chk("to_rdata_zero", data_rdata_o, 32'h0);
    step();
    chk("to_err_pulse", bus_err_o, 1'b0);

    // Ack arriving on the last timeout cycle completes normally
    ack_delay = TO - 1; rd_val = 32'hCAFE_F00D;
    data_addr_i = 32'h304; data_ce_i = 1'b1;
    run_txn(1'b0, "late_ack", cyc, s_addr, s_wdata, s_sel, s_we);
    chk("late_ce_cycles", cyc, TO);
    chk("late_no_err", bus_err_o, 1'b0);
    chk("late_rdata", data_rdata_o, 32'hCAFE_F00D);
    step();

    // Reset in the middle of a fetch
    ack_delay = -1;
    inst_addr_i = 32'h40; inst_ce_i = 1'b1;
    repeat (4) step();
    chk("rb_busy", mem_ce_o, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_zero("rb_async");
    seen = 1'b0;
    repeat (2) begin
      step();
      if (inst_ready_o || data_ready_o || mem_ce_o) seen = 1'b1;
    end
    chk("rb_quiet", seen, 1'b0);
    ack_delay = 1; rd_val = 32'h0BAD_C0DE;
    rst = 1'b1;
    run_txn(1'b1, "rb_resume", cyc, s_addr, s_wdata, s_sel, s_we);
    chk("rb_addr", s_addr, 32'h40);
    chk("rb_ce_cycles", cyc, 2);
    chk("rb_idata", inst_data_o, 32'h0BAD_C0DE);
    step();

    // Randomized traffic from both masters against a random responder
    rand_resp = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (inst_ce_i && inst_ready_o) inst_ce_i = 1'b0;
      else if (inst_ce_i && $urandom_range(0, 63) == 0) inst_ce_i = 1'b0;
      else if (!inst_ce_i && $urandom_range(0, 2) == 0) begin
        inst_ce_i = 1'b1;
        inst_addr_i = AW'($urandom);
      end
      if (data_ce_i && data_ready_o) data_ce_i = 1'b0;
      else if (data_ce_i && $urandom_range(0, 63) == 0) data_ce_i = 1'b0;
      else if (!data_ce_i && $urandom_range(0, 2) == 0) begin
        data_ce_i = 1'b1;
        data_we_i = 1'($urandom_range(0, 1));
        data_addr_i = AW'($urandom);
        data_wdata_i = DW'($urandom);
        data_sel_i = SW'($urandom);
      end
    end
    inst_ce_i = 1'b0; data_ce_i = 1'b0;
    rand_resp = 1'b0; ack_delay = 0;
    repeat (25) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
